// File: rtl/rc4_prga_engine_pkg.sv
// Shared RC4 definitions: byte type, memory-mux encodings and the PRGA state enum.
// Used by the PRGA engine, its bus interface and the plaintext check.
package rc4_pkg;

    typedef logic [7:0] byte_t;
    typedef logic [1:0] mem_sel_t;

    localparam mem_sel_t MEM_S   = 2'd0;
    localparam mem_sel_t MEM_ENC = 2'd1;
    localparam mem_sel_t MEM_DEC = 2'd2;

    typedef enum logic [3:0] {
        IDLE,
        INC_I,
        RD_SI,
        ADD_J,
        RD_SJ,
        WR_SI,
        WR_SJ,
        RD_F,
        RD_ENC,
        CHECK,
        WR_DEC,
        NEXT,
        DONE
    } state_t;

endpackage

// File: rtl/rc4_prga_engine_if.sv
// Muxed memory port shared by the S RAM, encrypted ROM and decrypted RAM.
// The engine drives it through the master modport.
interface rc4_prga_engine_if;
    import rc4_pkg::*;

    logic     mem_req;
    mem_sel_t memory_sel;
    byte_t    address;
    byte_t    data;
    logic     wen;
    byte_t    q_data;

    modport master (output mem_req, memory_sel, address, data, wen, input q_data);
    modport slave  (input mem_req, memory_sel, address, data, wen, output q_data);

endinterface

// File: rtl/rc4_prga_engine_char_check.sv
// Combinational plaintext legality predicate: a byte inside [CHAR_LO, CHAR_HI],
// or a space when ALLOW_SPACE is set. Shared with the key-search controller.
module rc4_char_check
    import rc4_pkg::*;
#(
    parameter byte_t CHAR_LO     = 8'h61,
    parameter byte_t CHAR_HI     = 8'h7A,
    parameter int    ALLOW_SPACE = 1
) (
    input  byte_t ch,
    output logic  legal
);

    always_comb begin
        legal = ((ch >= CHAR_LO) && (ch <= CHAR_HI)) ||
                ((ALLOW_SPACE != 0) && (ch == 8'h20));
    end

endmodule

// File: rtl/rc4_prga_engine.sv
// RC4 keystream (PRGA) decrypt engine: swaps S, XORs keystream with ciphertext
// and writes plaintext, optionally aborting on the first illegal plaintext byte.
module rc4_prga_engine
    import rc4_pkg::*;
#(
    parameter int    MSG_LEN     = 32,
    parameter int    RD_LAT      = 1,
    parameter int    CHECK_EN    = 1,
    parameter byte_t CHAR_LO     = 8'h61,
    parameter byte_t CHAR_HI     = 8'h7A,
    parameter int    ALLOW_SPACE = 1
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  start,
    output logic  finish,
    output logic  pass,
    output byte_t fail_index,
    rc4_prga_engine_if.master mem
);

    localparam logic [1:0] LAT    = 2'(RD_LAT);
    localparam logic [8:0] LAST_K = 9'(MSG_LEN - 1);

    state_t     state, state_next;
    logic [1:0] wait_cnt;
    byte_t      i, j, si, sj, f, c, p;
    logic [8:0] k;
    logic       legal;
    logic       rd_done;
    logic       reject;

    rc4_char_check #(
        .CHAR_LO     (CHAR_LO),
        .CHAR_HI     (CHAR_HI),
        .ALLOW_SPACE (ALLOW_SPACE)
    ) u_check (
        .ch    (p),
        .legal (legal)
    );

    assign p       = f ^ c;
    assign rd_done = (wait_cnt == 2'd0);
    assign reject  = (CHECK_EN != 0) && !legal;

    // NEXT also performs the following byte's i increment, so INC_I runs only once per message.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = INC_I;
            INC_I:   state_next = RD_SI;
            RD_SI:   if (rd_done) state_next = ADD_J;
            ADD_J:   state_next = RD_SJ;
            RD_SJ:   if (rd_done) state_next = WR_SI;
            WR_SI:   state_next = WR_SJ;
            WR_SJ:   state_next = RD_F;
            RD_F:    if (rd_done) state_next = RD_ENC;
            RD_ENC:  if (rd_done) state_next = CHECK;
            CHECK:   state_next = reject ? DONE : WR_DEC;
            WR_DEC:  state_next = NEXT;
            NEXT:    state_next = (k == LAST_K) ? DONE : RD_SI;
            DONE:    if (!start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        finish          = (state == DONE);
        mem.mem_req     = (state != IDLE) && (state != DONE);
        mem.memory_sel  = MEM_S;
        mem.address     = 8'h00;
        mem.data        = 8'h00;
        mem.wen         = 1'b0;
        case (state)
            RD_SI:  mem.address = i;
            RD_SJ:  mem.address = j;
            WR_SI: begin
                mem.address = i;
                mem.data    = sj;
                mem.wen     = 1'b1;
            end
            WR_SJ: begin
                mem.address = j;
                mem.data    = si;
                mem.wen     = 1'b1;
            end
            RD_F:   mem.address = si + sj;
            RD_ENC: begin
                mem.memory_sel = MEM_ENC;
                mem.address    = k[7:0];
            end
            WR_DEC: begin
                mem.memory_sel = MEM_DEC;
                mem.address    = k[7:0];
                mem.data       = p;
                mem.wen        = 1'b1;
            end
            default: ;
        endcase
        // A write must never land in the cycle that reset is aborting.
        if (reset) mem.wen = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= 2'd0;
            i          <= 8'h00;
            j          <= 8'h00;
            k          <= 9'd0;
            si         <= 8'h00;
            sj         <= 8'h00;
            f          <= 8'h00;
            c          <= 8'h00;
            pass       <= 1'b0;
            fail_index <= 8'h00;
        end else begin
            state <= state_next;
            if (state_next != state)
                wait_cnt <= LAT;
            else if (wait_cnt != 2'd0)
                wait_cnt <= wait_cnt - 2'd1;

            case (state)
                IDLE: begin
                    if (start) begin
                        i          <= 8'h00;
                        j          <= 8'h00;
                        k          <= 9'd0;
                        pass       <= 1'b0;
                        fail_index <= 8'h00;
                    end
                end
                INC_I:  i <= i + 8'd1;
                RD_SI:  if (rd_done) si <= mem.q_data;
                ADD_J:  j <= j + si;
                RD_SJ:  if (rd_done) sj <= mem.q_data;
                RD_F:   if (rd_done) f  <= mem.q_data;
                RD_ENC: if (rd_done) c  <= mem.q_data;
                CHECK: begin
                    if (reject) begin
                        pass       <= 1'b0;
                        fail_index <= k[7:0];
                    end
                end
                NEXT: begin
                    k <= k + 9'd1;
                    i <= i + 8'd1;
                    if (k == LAST_K) pass <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
